// File: rtl/delay_scheduler.sv
// delay_scheduler: pops one deadline at a time from the timestamp FIFO, waits
// until the free-running counter reaches it, then fires one pulse_trigger.
// Late deadlines and deadlines that fall due while the pulse generator is
// busy are resolved here and counted in saturating counters.
//
// Build option: DELAY_SCHEDULER_LATE_FIRE_EN
//   defined   - a late deadline is counted and still fired at once (or counted
//               as a collision too if the generator is busy).
//   undefined - a late deadline is counted and dropped.
//
// Strobe semantics: fifo_rden and pulse_trigger are single-cycle registered
// strobes with no back-pressure. The FIFO must present fifo_data_out in the
// cycle after fifo_rden; pulse_trigger starts the generator unconditionally.
module delay_scheduler #(
  parameter int CTR_WIDTH = 18,
  parameter int LEAD_MAX  = 165000,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sched_en,
  input  logic                 cnt_clr,
  input  logic [CTR_WIDTH-1:0] ctr,
  input  logic                 fifo_empty,
  input  logic [CTR_WIDTH-1:0] fifo_data_out,
  output logic                 fifo_rden,
  input  logic                 pulse_busy,
  output logic                 pulse_trigger,
  output logic                 sched_busy,
  output logic [CNT_WIDTH-1:0] miss_cnt,
  output logic [CNT_WIDTH-1:0] coll_cnt,
  output logic [2:0]           dbg_state
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    POP  = 3'd1,
    LOAD = 3'd2,
    WAIT = 3'd3,
    FIRE = 3'd4
  } state_t;

  localparam logic [CTR_WIDTH-1:0] LEAD_MAX_V = CTR_WIDTH'(LEAD_MAX);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX    = {CNT_WIDTH{1'b1}};

  state_t               state;
  state_t               next_state;
  logic [CTR_WIDTH-1:0] deadline;
  logic [CTR_WIDTH-1:0] diff_load;
  logic [CTR_WIDTH-1:0] diff_wait;
  logic                 late;
  logic                 inc_miss;
  logic                 inc_coll;

  // Modular distances to the deadline; a wrapped (negative) distance shows up
  // as a value above LEAD_MAX and is treated as late.
  assign diff_load = fifo_data_out - ctr;
  assign diff_wait = deadline - ctr;
  assign late      = (diff_load > LEAD_MAX_V);
  assign dbg_state = state;

  // Next-state decode and counter increment requests.
  always_comb begin
    next_state = state;
    inc_miss   = 1'b0;
    inc_coll   = 1'b0;
    case (state)
      IDLE: if (sched_en && !fifo_empty) next_state = POP;
      POP:  next_state = sched_en ? LOAD : IDLE;
      LOAD: begin
        if (!sched_en) begin
          next_state = IDLE;
        end else if (late) begin
          inc_miss = 1'b1;
`ifdef DELAY_SCHEDULER_LATE_FIRE_EN
          if (pulse_busy) begin
            inc_coll   = 1'b1;
            next_state = IDLE;
          end else begin
            next_state = FIRE;
          end
`else
          next_state = IDLE;
`endif
        end else if (diff_load == '0) begin
          // Already due: ctr moves on next cycle, so WAIT would never match.
          if (pulse_busy) begin
            inc_coll   = 1'b1;
            next_state = IDLE;
          end else begin
            next_state = FIRE;
          end
        end else begin
          next_state = WAIT;
        end
      end
      WAIT: begin
        if (!sched_en) begin
          next_state = IDLE;
        end else if (diff_wait == '0) begin
          if (pulse_busy) begin
            inc_coll   = 1'b1;
            next_state = IDLE;
          end else begin
            next_state = FIRE;
          end
        end
      end
      FIRE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // State register with registered strobes decoded from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      fifo_rden     <= 1'b0;
      pulse_trigger <= 1'b0;
      sched_busy    <= 1'b0;
    end else begin
      state         <= next_state;
      fifo_rden     <= (next_state == POP);
      pulse_trigger <= (next_state == FIRE);
      sched_busy    <= (next_state != IDLE);
    end
  end

  // Capture the popped deadline while in LOAD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deadline <= '0;
    end else if (state == LOAD) begin
      deadline <= fifo_data_out;
    end
  end

  // Saturating event counters; a clear beats a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miss_cnt <= '0;
      coll_cnt <= '0;
    end else if (cnt_clr) begin
      miss_cnt <= '0;
      coll_cnt <= '0;
    end else begin
      if (inc_miss && (miss_cnt != CNT_MAX)) miss_cnt <= miss_cnt + 1'b1;
      if (inc_coll && (coll_cnt != CNT_MAX)) coll_cnt <= coll_cnt + 1'b1;
    end
  end

endmodule
